vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 50 MHz board clock. It produces the pixel-rate strobe, the horizontal and vertical counters, the active-area pixel coordinates, and the VGA_HS / VGA_VS / VGA_BLANK_N / VGA_SYNC_N / VGA_CLK pins. It sits directly upstream of the Project1 pixel/colour logic, which consumes x, y, active and pix_en, and it drives the DAC control pins at the top level.

## Interface
- CLK_DIV, 2: board clocks per pixel; must be ≥1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- clk  in  1  board clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-high.
- pix_en  out  1  one-clk strobe, once every CLK_DIV clocks.
- h_count  out  10  horizontal position, 0..H_TOTAL-1.
- v_count  out  10  vertical position, 0..V_TOTAL-1.
- x  out  10  equals h_count when active, else 0.
- y  out  10  equals v_count when active, else 0.
- active  out  1  high when h_count<H_ACTIVE and v_count<V_ACTIVE.
- line_start  out  1  one-clk pulse when h_count wraps to 0.
- frame_start  out  1  one-clk pulse when both counters wrap to 0.
- VGA_HS  out  1  horizontal sync, active-low.
- VGA_VS  out  1  vertical sync, active-low.
- VGA_BLANK_N  out  1  equals active.
- VGA_SYNC_N  out  1  tied 0.
- VGA_CLK  out  1  pixel clock to the DAC.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Divider `div` counts 0..CLK_DIV-1 and wraps. pix_en=1 in the clk where div==CLK_DIV-1.
- h_count and v_count change only when pix_en=1:
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - v_count increments on the h wrap; at V_TOTAL-1 it wraps to 0.
- HS is low for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- VS is low for v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- VGA_CLK = (div ≥ CLK_DIV/2). When CLK_DIV=1, VGA_CLK = ~clk-phase is not allowed; drive VGA_CLK=1 instead.
- Reset values: div=0, h_count=0, v_count=0, pix_en=0, line_start=0, frame_start=0, active=1, x=0, y=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=1, VGA_SYNC_N=0.
- No frame_start or line_start is emitted at reset release. The first of each fires on the first counter wrap.
- Reset asserted mid-frame restores all reset values on the next clk edge, regardless of div phase.

## Timing
- All outputs are registered.
- HS, VS, active, x, y, BLANK_N are decoded from the next-state counter values. They therefore change in the same clk as h_count/v_count, with zero skew between counters and sync pins.
- line_start and frame_start are high in the same clk in which the counters show the wrapped value. That is the clk after the pix_en that caused the wrap.
- Consumer contract: pixel data for (x,y) must be presented by the clk in which the next pix_en is high.
- Line period = H_TOTAL*CLK_DIV = 1600 clk.
- Frame period = 840000 clk.

## Structure
- Package vga_pkg holds:
  - default timing constants;
  - H_TOTAL and V_TOTAL;
  - the counter width localparam (10).
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical). Its parameters are ACTIVE, FP, SYNC and BP. Its ports are clk, reset, step, count, wrap, sync_n and in_active.
- The divider and the output registers live in the top.

## Test plan
- Reset held for 3 clk, then released → all outputs at reset values. First pix_en appears at clk 2 after release (CLK_DIV=2), then every 2 clk.
- Run one line → VGA_HS falls when h_count becomes 656 and rises when it becomes 752. line_start pulses exactly once, 1600 clk after the first count.
- Run one full frame → VGA_VS is low for exactly 2 lines (v_count 490–491). frame_start pulses once, 840000 clk after reset release.
- Blank check → at h_count=639 active=1 and x=639. At h_count=640 active=0, x=0 and VGA_BLANK_N=0. At v_count=480, active=0 for the whole line.
- Assert reset at h_count=700, v_count=491 (HS and VS both low) → next clk: counters 0, HS=1, VS=1, no frame_start pulse.
- CLK_DIV=1 build → pix_en is constantly 1 and the counters advance every clk. Frame = 420000 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the counter type and the axis-counter step function.
package vga_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int CLK_DIV_DEF  = 2;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Next value of an axis counter: hold, wrap to zero, or advance by one.
  function automatic cnt_t axis_next(input cnt_t cur, input logic step, input logic wrap);
    cnt_t nxt;
    if (!step) begin
      nxt = cur;
    end else if (wrap) begin
      nxt = '0;
    end else begin
      nxt = cur + cnt_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel/colour logic and the DAC pins.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic pix_en;
  cnt_t h_count;
  cnt_t v_count;
  cnt_t x;
  cnt_t y;
  logic active;
  logic line_start;
  logic frame_start;
  logic VGA_HS;
  logic VGA_VS;
  logic VGA_BLANK_N;
  logic VGA_SYNC_N;
  logic VGA_CLK;

  // No valid/ready: pix_en is a free-running strobe with no backpressure. The
  // consumer must present pixel data for (x,y) by the clk in which the next pix_en is high.
  modport master (
    output pix_en, h_count, v_count, x, y, active, line_start, frame_start,
           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );

  modport slave (
    input pix_en, h_count, v_count, x, y, active, line_start, frame_start,
          VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus sync/active decode of its next-state value.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output cnt_t count,
  output logic wrap,
  output logic sync_n,
  output logic in_active
);

  localparam int   TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT_END = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_LO = cnt_t'(ACTIVE + FP);
  localparam cnt_t SYNC_HI = cnt_t'(ACTIVE + FP + SYNC - 1);

  cnt_t count_q;
  cnt_t count_d;

  assign wrap    = step && (count_q == LAST);
  assign count_d = axis_next(count_q, step, wrap);

  // Decoded from count_d so the top can register them alongside the counter.
  assign sync_n    = !((count_d >= SYNC_LO) && (count_d <= SYNC_HI));
  assign in_active = (count_d < ACT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate divider, h/v axis counters and registered sync/blank pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int               DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX     = DIV_W'(CLK_DIV - 1);
  localparam logic             VGA_CLK_RST = (CLK_DIV == 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             pix_en_q;
  logic             pix_en_d;
  logic             vga_clk_q;
  logic             vga_clk_d;
  logic             line_start_q;
  logic             frame_start_q;
  logic             active_q;
  logic             active_d;
  logic             hs_q;
  logic             vs_q;
  cnt_t             x_q;
  cnt_t             x_d;
  cnt_t             y_q;
  cnt_t             y_d;

  cnt_t h_count;
  cnt_t v_count;
  cnt_t h_next;
  cnt_t v_next;
  logic h_wrap;
  logic v_wrap;
  logic h_sync_n;
  logic v_sync_n;
  logic h_act;
  logic v_act;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .reset     (reset),
    .step      (pix_en_q),
    .count     (h_count),
    .wrap      (h_wrap),
    .sync_n    (h_sync_n),
    .in_active (h_act)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .reset     (reset),
    .step      (h_wrap),
    .count     (v_count),
    .wrap      (v_wrap),
    .sync_n    (v_sync_n),
    .in_active (v_act)
  );

  assign div_d    = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
  assign pix_en_d = (div_d == DIV_MAX);

  // A divide-by-one pixel clock cannot be phase-split, so it is held high.
  generate
    if (CLK_DIV == 1) begin : g_clk_undivided
      assign vga_clk_d = 1'b1;
    end else begin : g_clk_divided
      localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
      assign vga_clk_d = (div_d >= DIV_HALF);
    end
  endgenerate

  assign h_next   = axis_next(h_count, pix_en_q, h_wrap);
  assign v_next   = axis_next(v_count, h_wrap, v_wrap);
  assign active_d = h_act && v_act;
  assign x_d      = active_d ? h_next : '0;
  assign y_d      = active_d ? v_next : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      vga_clk_q     <= VGA_CLK_RST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      active_q      <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= h_sync_n;
      vs_q          <= v_sync_n;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.h_count     = h_count;
  assign vga.v_count     = v_count;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.active      = active_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = active_q;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_CLK     = vga_clk_q;

endmodule
